// File: rtl/ddf_pkg.sv
// Shared constants for the block statistics front end: data widths,
// pipeline depth and the default 1080p geometry.
package ddf_pkg;

    localparam int WD_W    = 3;     // pixel weight width
    localparam int RGB_W   = 24;    // packed {R,G,B} width
    localparam int LATENCY = 3;     // input-to-output pipeline depth

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_KH       = 16;
    localparam int DEF_KV       = 9;

    typedef logic [WD_W-1:0]  wd_t;
    typedef logic [RGB_W-1:0] rgb_t;

endpackage

// File: rtl/block_weight_gen_luma_weight.sv
// luma_weight: RGB -> 3-bit brightness weight, three register stages.
// Build option: LUMA_EXACT_EN selects the 77/150/29 weighted luma; the
// default build uses the cheaper (2R + 5G + B) / 8 shift-add form.
module luma_weight
    import ddf_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] rgb_i,
    output logic [2:0]  wd_o
);

    logic [WD_W-1:0] r_wd;
    logic            w_unused;

`ifdef LUMA_EXACT_EN
    logic [15:0] r_pr;
    logic [15:0] r_pg;
    logic [15:0] r_pb;
    logic [15:0] r_sum;

    // Stage 1 multiplies, stage 2 sums (max 255*256 fits 16 bits), stage 3 keeps Y[7:5].
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pr  <= '0;
            r_pg  <= '0;
            r_pb  <= '0;
            r_sum <= '0;
            r_wd  <= '0;
        end else begin
            r_pr  <= {8'd0, rgb_i[23:16]} * 16'd77;
            r_pg  <= {8'd0, rgb_i[15:8]}  * 16'd150;
            r_pb  <= {8'd0, rgb_i[7:0]}   * 16'd29;
            r_sum <= r_pr + r_pg + r_pb;
            r_wd  <= r_sum[15:13];
        end
    end

    assign w_unused = ^r_sum[12:0];
`else
    logic [RGB_W-1:0] r_rgb;
    logic [10:0]      r_sum;   // 11 bits so the full-white sum 2040 fits

    // Stage 1 registers the pixel, stage 2 forms 2R+5G+B, stage 3 keeps Y[7:5].
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rgb <= '0;
            r_sum <= '0;
            r_wd  <= '0;
        end else begin
            r_rgb <= rgb_i;
            r_sum <= ({3'd0, r_rgb[23:16]} << 1)
                   + ({3'd0, r_rgb[15:8]}  << 2)
                   +  {3'd0, r_rgb[15:8]}
                   +  {3'd0, r_rgb[7:0]};
            r_wd  <= r_sum[10:8];
        end
    end

    assign w_unused = ^r_sum[7:0];
`endif

    assign wd_o = r_wd;

endmodule

// File: rtl/block_weight_gen.sv
// block_weight_gen: turns the video stream into per-pixel weights tagged
// with block coordinates, plus an end-of-frame freeze strobe for the
// accumulator array. Build option LUMA_EXACT_EN (see luma_weight) changes
// only the luma arithmetic; ports and timing are identical.
module block_weight_gen
    import ddf_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   KH       = DEF_KH,
    parameter int   KV       = DEF_KV,
    parameter logic VS_POL   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vs_i,
    input  logic                  de_i,
    input  logic [23:0]           rgb_i,
    output logic                  de_o,
    output logic [2:0]            wd_o,
    output logic [$clog2(KH)-1:0] blk_x_o,
    output logic [$clog2(KV)-1:0] blk_y_o,
    output logic                  freeze_o
);

    localparam int BW   = H_ACTIVE / KH;    // pixels per block column
    localparam int LH   = V_ACTIVE / KV;    // lines per block row
    localparam int PX_W = $clog2(BW + 1);
    localparam int LN_W = $clog2(LH + 1);
    localparam int BX_W = $clog2(KH);
    localparam int BY_W = $clog2(KV);
    localparam int ST_W = 2 + BX_W + BY_W;  // {de, freeze, blk_x, blk_y}

    localparam logic [PX_W-1:0] PX_LAST = PX_W'(BW - 1);
    localparam logic [LN_W-1:0] LN_LAST = LN_W'(LH - 1);
    localparam logic [BX_W-1:0] BX_LAST = BX_W'(KH - 1);
    localparam logic [BY_W-1:0] BY_LAST = BY_W'(KV - 1);

    logic            r_vs_act;
    logic            r_de_prev;
    logic            r_synced;
    logic [PX_W-1:0] r_px_cnt;
    logic [LN_W-1:0] r_ln_cnt;
    logic [BX_W-1:0] r_blk_x;
    logic [BY_W-1:0] r_blk_y;

    logic            w_vs_act;
    logic            w_vs_edge;
    logic            w_de_fall;
    logic            w_de_s0;
    logic [WD_W-1:0] w_wd;

    logic [ST_W-1:0] w_stage_in [LATENCY];
    logic [ST_W-1:0] r_stage    [LATENCY];

    assign w_vs_act  = (vs_i == VS_POL);
    assign w_vs_edge = w_vs_act & ~r_vs_act;
    assign w_de_fall = r_de_prev & ~de_i;
    // The pixel coinciding with the vs edge is dropped so freeze never overlaps a weight.
    assign w_de_s0   = de_i & r_synced & ~w_vs_edge;

    // Edge-detect history and the sync flag; a vs edge also closes any open line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vs_act  <= 1'b0;
            r_de_prev <= 1'b0;
            r_synced  <= 1'b0;
        end else begin
            r_vs_act  <= w_vs_act;
            r_de_prev <= w_vs_edge ? 1'b0 : de_i;
            if (w_vs_edge) begin
                r_synced <= 1'b1;
            end
        end
    end

    // Block counters: pixels within a block column, lines within a block row,
    // both with saturating block indices for over-long lines or frames.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_vs_edge) begin
            r_px_cnt <= '0;
            r_ln_cnt <= '0;
            r_blk_x  <= '0;
            r_blk_y  <= '0;
        end else if (w_de_fall) begin
            r_px_cnt <= '0;
            r_blk_x  <= '0;
            if (r_ln_cnt == LN_LAST) begin
                r_ln_cnt <= '0;
                if (r_blk_y != BY_LAST) begin
                    r_blk_y <= r_blk_y + 1'b1;
                end
            end else begin
                r_ln_cnt <= r_ln_cnt + 1'b1;
            end
        end else if (de_i) begin
            if (r_px_cnt == PX_LAST) begin
                r_px_cnt <= '0;
                if (r_blk_x != BX_LAST) begin
                    r_blk_x <= r_blk_x + 1'b1;
                end
            end else begin
                r_px_cnt <= r_px_cnt + 1'b1;
            end
        end
    end

    // Control/coordinate delay line matched to the luma pipeline depth.
    assign w_stage_in[0] = {w_de_s0, w_vs_edge, r_blk_x, r_blk_y};

    genvar gi;
    generate
        for (gi = 1; gi < LATENCY; gi++) begin : g_dly
            assign w_stage_in[gi] = r_stage[gi-1];
        end
    endgenerate

    // Advance the delay line; reset flushes any in-flight weights.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= w_stage_in[i];
            end
        end
    end

    luma_weight u_luma (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rgb_i (rgb_i),
        .wd_o  (w_wd)
    );

    assign {de_o, freeze_o, blk_x_o, blk_y_o} = r_stage[LATENCY-1];
    // Weight is forced to 0 outside valid cycles so idle outputs stay clean.
    assign wd_o = w_wd & {WD_W{de_o}};

endmodule

// File: tb/tb_block_weight_gen.sv
// Directed bench for block_weight_gen with a 32x18 frame split into 4x3
// blocks. Expected weights follow LUMA_EXACT_EN when it is defined.
module tb_block_weight_gen;

    localparam int H_ACTIVE = 32;
    localparam int V_ACTIVE = 18;
    localparam int KH       = 4;
    localparam int KV       = 3;
    localparam int MAXC     = 8192;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        vs_i = 1'b0;
    logic        de_i = 1'b0;
    logic [23:0] rgb_i = '0;
    logic        de_o;
    logic [2:0]  wd_o;
    logic [1:0]  blk_x_o;
    logic [1:0]  blk_y_o;
    logic        freeze_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic       obs_de  [MAXC];
    logic [2:0] obs_wd  [MAXC];
    logic [1:0] obs_bx  [MAXC];
    logic [1:0] obs_by  [MAXC];
    logic       obs_frz [MAXC];

    always #5 clk = ~clk;

    block_weight_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .KH       (KH),
        .KV       (KV),
        .VS_POL   (1'b1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .vs_i     (vs_i),
        .de_i     (de_i),
        .rgb_i    (rgb_i),
        .de_o     (de_o),
        .wd_o     (wd_o),
        .blk_x_o  (blk_x_o),
        .blk_y_o  (blk_y_o),
        .freeze_o (freeze_o)
    );

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: drive inputs, wait past the edge, record the outputs.
    // Inputs driven in step c show up in obs[c+2].
    task automatic step(input logic rst, input logic vs, input logic de, input logic [23:0] rgb);
        rst_i = rst;
        vs_i  = vs;
        de_i  = de;
        rgb_i = rgb;
        @(posedge clk);
        #1;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        obs_de[cyc]  = de_o;
        obs_wd[cyc]  = wd_o;
        obs_bx[cyc]  = blk_x_o;
        obs_by[cyc]  = blk_y_o;
        obs_frz[cyc] = freeze_o;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic drive_line(input int npx, input logic [23:0] rgb, input int gap, output int start);
        start = cyc;
        repeat (npx) step(1'b0, 1'b0, 1'b1, rgb);
        idle(gap);
    endtask

    // vs active for two cycles; the edge is in the returned cycle.
    task automatic vs_pulse(output int c);
        c = cyc;
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b1, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_reset;
        int c;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
        c = cyc - 1;
        n_checks++;
        if (obs_de[c] !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", obs_de[c]); end
        n_checks++;
        if (obs_wd[c] !== 3'd0) begin n_fail++; $display("FAIL reset_wd: got %0d want 0", obs_wd[c]); end
        n_checks++;
        if (obs_bx[c] !== 2'd0) begin n_fail++; $display("FAIL reset_blk_x: got %0d want 0", obs_bx[c]); end
        n_checks++;
        if (obs_by[c] !== 2'd0) begin n_fail++; $display("FAIL reset_blk_y: got %0d want 0", obs_by[c]); end
        n_checks++;
        if (obs_frz[c] !== 1'b0) begin n_fail++; $display("FAIL reset_freeze: got %b want 0", obs_frz[c]); end
        $display("test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_no_sync;
        int s, d;
        s = cyc;
        for (int l = 0; l < 3; l++) drive_line(32, 24'hFFFFFF, 4, d);
        idle(2);
        for (int i = s; i < cyc; i++) begin
            n_checks++;
            if ({obs_de[i], obs_frz[i]} !== 2'b00) begin
                n_fail++;
                $display("FAIL no_sync cyc %0d: de/freeze got %b%b want 00", i, obs_de[i], obs_frz[i]);
            end
        end
        $display("test_no_sync done at cycle %0d", cyc);
    endtask

    task automatic test_line_white;
        int cv, s;
        logic [7:0] got, exp;
        vs_pulse(cv);
        idle(2);
        n_checks++;
        if (obs_frz[cv+2] !== 1'b1) begin n_fail++; $display("FAIL freeze_pulse: got %b want 1", obs_frz[cv+2]); end
        n_checks++;
        if ({obs_frz[cv+1], obs_frz[cv+3]} !== 2'b00) begin
            n_fail++; $display("FAIL freeze_width: neighbours got %b%b want 00", obs_frz[cv+1], obs_frz[cv+3]);
        end
        drive_line(32, 24'hFFFFFF, 4, s);
        for (int p = 0; p < 32; p++) begin
            got = {obs_de[s+p+2], obs_wd[s+p+2], obs_bx[s+p+2], obs_by[s+p+2]};
            exp = {1'b1, 3'd7, 2'(p / 8), 2'd0};
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL white px %0d: {de,wd,bx,by} got %b want %b", p, got, exp); end
        end
        n_checks++;
        if (obs_de[s+34] !== 1'b0) begin n_fail++; $display("FAIL white_end: de got %b want 0", obs_de[s+34]); end
        $display("test_line_white done at cycle %0d", cyc);
    endtask

    task automatic test_colors;
        logic [23:0] col [8];
        int          ewd [8];
        int          s;
        logic [7:0]  got, exp;
        col[0] = 24'h000000; ewd[0] = 0;
        col[1] = 24'h808080; ewd[1] = 4;
`ifdef LUMA_EXACT_EN
        col[2] = 24'hFF0000; ewd[2] = 2;
`else
        col[2] = 24'hFF0000; ewd[2] = 1;
`endif
        col[3] = 24'hFFFFFF; ewd[3] = 7;
        col[4] = 24'h00FF00; ewd[4] = 4;
        col[5] = 24'h0000FF; ewd[5] = 0;
        col[6] = 24'h404040; ewd[6] = 2;
        col[7] = 24'h123456; ewd[7] = 1;
        s = cyc;
        for (int p = 0; p < 32; p++) step(1'b0, 1'b0, 1'b1, col[p % 8]);
        idle(4);
        for (int p = 0; p < 32; p++) begin
            got = {obs_de[s+p+2], obs_wd[s+p+2], obs_bx[s+p+2], obs_by[s+p+2]};
            exp = {1'b1, 3'(ewd[p % 8]), 2'(p / 8), 2'd0};
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL color px %0d rgb %h: {de,wd,bx,by} got %b want %b", p, col[p % 8], got, exp); end
        end
        $display("test_colors done at cycle %0d", cyc);
    endtask

    task automatic test_frame;
        int cv, cv2, s, lastc;
        logic [23:0] rgb;
        logic [2:0]  w;
        logic [7:0]  got, exp;
        vs_pulse(cv);
        idle(1);
        lastc = 0;
        for (int l = 0; l < 18; l++) begin
            rgb = (l % 2 == 0) ? 24'hFFFFFF : 24'h000000;
            w   = (l % 2 == 0) ? 3'd7 : 3'd0;
            drive_line(32, rgb, 3, s);
            lastc = s + 31;
            for (int p = 0; p < 32; p++) begin
                got = {obs_de[s+p+2], obs_wd[s+p+2], obs_bx[s+p+2], obs_by[s+p+2]};
                exp = {1'b1, w, 2'(p / 8), 2'(l / 6)};
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL frame line %0d px %0d: got %b want %b", l, p, got, exp); end
            end
        end
        vs_pulse(cv2);
        n_checks++;
        if (obs_de[lastc+2] !== 1'b1) begin n_fail++; $display("FAIL frame_last_de: got %b want 1", obs_de[lastc+2]); end
        n_checks++;
        if (obs_frz[cv2+2] !== 1'b1) begin n_fail++; $display("FAIL frame_freeze: got %b want 1", obs_frz[cv2+2]); end
        for (int i = cv; i < cyc; i++) begin
            n_checks++;
            if (obs_de[i] && obs_frz[i]) begin n_fail++; $display("FAIL overlap cyc %0d: de and freeze both 1, want not both", i); end
        end
        $display("test_frame done at cycle %0d", cyc);
    endtask

    task automatic test_vs_during_de;
        int cv;
        logic [7:0] got, exp;
        repeat (5) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        cv = cyc;
        step(1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b0, 1'b1, 1'b1, 24'hFFFFFF);
        repeat (8) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        idle(4);
        n_checks++;
        if (obs_de[cv+1] !== 1'b1) begin n_fail++; $display("FAIL pre_vs_px: de got %b want 1", obs_de[cv+1]); end
        n_checks++;
        if ({obs_de[cv+2], obs_frz[cv+2]} !== 2'b01) begin
            n_fail++; $display("FAIL vs_px_suppress: de/freeze got %b%b want 01", obs_de[cv+2], obs_frz[cv+2]);
        end
        for (int k = 0; k < 10; k++) begin
            got = {obs_de[cv+3+k], obs_wd[cv+3+k], obs_bx[cv+3+k], obs_by[cv+3+k]};
            exp = {1'b1, 3'd7, 2'(k / 8), 2'd0};
            n_checks++;
            if (got !== exp) begin n_fail++; $display("FAIL post_vs px %0d: got %b want %b", k, got, exp); end
        end
        $display("test_vs_during_de done at cycle %0d", cyc);
    endtask

    task automatic test_saturate;
        int cv, s;
        logic [7:0] got, exp;
        vs_pulse(cv);
        idle(1);
        for (int l = 0; l < 25; l++) begin
            drive_line(40, 24'h808080, 2, s);
            for (int p = 0; p < 40; p++) begin
                got = {obs_de[s+p+2], obs_wd[s+p+2], obs_bx[s+p+2], obs_by[s+p+2]};
                exp = {1'b1, 3'd4, 2'(imin(p / 8, 3)), 2'(imin(l / 6, 2))};
                n_checks++;
                if (got !== exp) begin n_fail++; $display("FAIL sat line %0d px %0d: got %b want %b", l, p, got, exp); end
            end
        end
        $display("test_saturate done at cycle %0d", cyc);
    endtask

    task automatic test_reset_mid;
        int cv, s, cr, d;
        logic [8:0] got;
        vs_pulse(cv);
        idle(1);
        s = cyc;
        repeat (5) step(1'b0, 1'b0, 1'b1, 24'hFFFFFF);
        cr = cyc;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        idle(4);
        n_checks++;
        if (obs_de[cr-1] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_px: de got %b want 1", obs_de[cr-1]); end
        for (int i = cr; i < cr + 4; i++) begin
            got = {obs_de[i], obs_wd[i], obs_bx[i], obs_by[i], obs_frz[i]};
            n_checks++;
            if (got !== 9'd0) begin n_fail++; $display("FAIL flush cyc %0d: {de,wd,bx,by,frz} got %b want 0", i, got); end
        end
        s = cyc;
        drive_line(32, 24'hFFFFFF, 4, d);
        for (int i = s; i < cyc; i++) begin
            n_checks++;
            if ({obs_de[i], obs_frz[i]} !== 2'b00) begin
                n_fail++; $display("FAIL unsynced cyc %0d: de/freeze got %b%b want 00", i, obs_de[i], obs_frz[i]);
            end
        end
        vs_pulse(cv);
        drive_line(32, 24'hFFFFFF, 4, s);
        n_checks++;
        if (obs_frz[cv+2] !== 1'b1) begin n_fail++; $display("FAIL resync_freeze: got %b want 1", obs_frz[cv+2]); end
        n_checks++;
        if ({obs_de[s+2], obs_wd[s+2], obs_bx[s+2], obs_by[s+2]} !== {1'b1, 3'd7, 2'd0, 2'd0}) begin
            n_fail++; $display("FAIL resync_px0: got %b want 11110000", {obs_de[s+2], obs_wd[s+2], obs_bx[s+2], obs_by[s+2]});
        end
        $display("test_reset_mid done at cycle %0d", cyc);
    endtask

    initial begin
        test_reset();
        test_no_sync();
        test_line_white();
        test_colors();
        test_frame();
        test_vs_during_de();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
